// File: rtl/debug_types.sv
// Shared debug-module types: abstract command encodings, cmderr codes,
// register-number map and the abstract sequencer state encoding.
package debug_types;

    localparam logic [7:0] CMDTYPE_ARC = 8'd0;
    localparam logic [7:0] CMDTYPE_QA  = 8'd1;
    localparam logic [7:0] CMDTYPE_AMC = 8'd2;

    localparam logic [2:0] CMDERR_NONE       = 3'd0;
    localparam logic [2:0] CMDERR_BUSY       = 3'd1;
    localparam logic [2:0] CMDERR_NOSUPPORT  = 3'd2;
    localparam logic [2:0] CMDERR_EXCEPTION  = 3'd3;
    localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;
    localparam logic [2:0] CMDERR_BUSERR     = 3'd5;
    localparam logic [2:0] CMDERR_OTHER      = 3'd7;

    localparam logic [2:0]  AARSIZE_32      = 3'd2;
    localparam logic [15:0] REGNO_GPR_FIRST = 16'h1000;
    localparam logic [15:0] REGNO_GPR_LAST  = 16'h101F;
    localparam logic [15:0] REGNO_CSR_LAST  = 16'h0FFF;

    localparam int BUS_AW = 12;

    typedef struct packed {
        logic [7:0]  cmdtype;
        logic        zero23;
        logic [2:0]  aarsize;
        logic        aarpostincrement;
        logic        postexec;
        logic        transfer;
        logic        write;
        logic [15:0] regno;
    } access_reg_cmd_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_DECODE,
        SEQ_ACCESS,
        SEQ_DONE
    } seq_state_e;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_GPR,
        TGT_CSR
    } access_target_e;

endpackage

// File: rtl/BBUS_IF.sv
// Debug register-access bus between the debug module and a core register file.
interface BBUS_IF;
    import debug_types::*;

    logic [BUS_AW-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              read_en;
    logic              write_en;
    logic              read_ack;
    logic              write_ack;

    modport master (output addr, wdata, read_en, write_en,
                    input  rdata, read_ack, write_ack);
    modport slave  (input  addr, wdata, read_en, write_en,
                    output rdata, read_ack, write_ack);
endinterface

// File: rtl/dbg_abstract_decode.sv
// Validates an Access Register command and picks the register file and
// bus address it targets; the first failing rule decides cmderr.
module dbg_abstract_decode
    import debug_types::*;
(
    input  access_reg_cmd_t   cmd,
    input  logic              halted,
    output access_target_e    target,
    output logic [BUS_AW-1:0] addr,
    output logic [2:0]        cmderr
);

    // Fields consumed by the sequencer rather than by the validation rules.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{cmd.zero23, cmd.aarpostincrement, cmd.write};

    always_comb begin
        target = TGT_NONE;
        addr   = '0;
        cmderr = CMDERR_NONE;
        if (cmd.cmdtype != CMDTYPE_ARC) begin
            cmderr = CMDERR_NOSUPPORT;
        end else if (!cmd.transfer) begin
            cmderr = cmd.postexec ? CMDERR_NOSUPPORT : CMDERR_NONE;
        end else if (cmd.postexec) begin
            cmderr = CMDERR_NOSUPPORT;
        end else if (cmd.aarsize != AARSIZE_32) begin
            cmderr = CMDERR_NOSUPPORT;
        end else if (!halted) begin
            cmderr = CMDERR_HALTRESUME;
        end else if (cmd.regno >= REGNO_GPR_FIRST && cmd.regno <= REGNO_GPR_LAST) begin
            target = TGT_GPR;
            addr   = BUS_AW'(cmd.regno[4:0]);
        end else if (cmd.regno <= REGNO_CSR_LAST) begin
            target = TGT_CSR;
            addr   = cmd.regno[BUS_AW-1:0];
        end else begin
            cmderr = CMDERR_EXCEPTION;
        end
    end

endmodule

// File: rtl/dbg_abstract_seq.sv
// Abstract-command sequencer: decodes an accepted Access Register command and
// performs one bounded-time GPR or CSR bus transfer, reporting cmderr.
module dbg_abstract_seq
    import debug_types::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        iClk,
    input  logic        nRst,
    input  logic        iStart,
    input  logic [31:0] iCommand,
    input  logic [31:0] iData0,
    input  logic        iHalted,
    input  logic        iAbort,
    output logic        oBusy,
    output logic        oDone,
    output logic [2:0]  oCmdErr,
    output logic [31:0] oRdata,
    output logic        oRdataValid,
    output logic [15:0] oRegnoNext,
    output logic        oRegnoInc,
    output logic        oStartRejected,
    BBUS_IF.master      rf_bus,
    BBUS_IF.master      csr_bus
);

    seq_state_e        state;
    access_reg_cmd_t   cmd_q;
    logic [31:0]       data0_q;
    access_target_e    tgt_q;
    access_target_e    dec_target;
    logic [BUS_AW-1:0] dec_addr;
    logic [2:0]        dec_cmderr;
    logic [BUS_AW-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic              rd_ok_q;
    logic [16:0]       wait_cnt;
    logic [16:0]       wait_cnt_inc;
    logic              is_gpr;
    logic              is_csr;
    logic              bus_ack;
    logic [31:0]       rdata_sel;

    dbg_abstract_decode u_decode (
        .cmd    (cmd_q),
        .halted (iHalted),
        .target (dec_target),
        .addr   (dec_addr),
        .cmderr (dec_cmderr)
    );

    assign is_gpr = (tgt_q == TGT_GPR);
    assign is_csr = (tgt_q == TGT_CSR);

    // The shared request registers are steered onto the targeted bus only.
    assign rf_bus.read_en   = rd_en_q && is_gpr;
    assign rf_bus.write_en  = wr_en_q && is_gpr;
    assign rf_bus.addr      = is_gpr ? addr_q : '0;
    assign rf_bus.wdata     = is_gpr ? wdata_q : '0;
    assign csr_bus.read_en  = rd_en_q && is_csr;
    assign csr_bus.write_en = wr_en_q && is_csr;
    assign csr_bus.addr     = is_csr ? addr_q : '0;
    assign csr_bus.wdata    = is_csr ? wdata_q : '0;

    assign bus_ack = (rd_en_q && (is_gpr ? rf_bus.read_ack  : csr_bus.read_ack)) ||
                     (wr_en_q && (is_gpr ? rf_bus.write_ack : csr_bus.write_ack));
    assign rdata_sel    = is_gpr ? rf_bus.rdata : csr_bus.rdata;
    assign wait_cnt_inc = wait_cnt + 17'd1;

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state      <= SEQ_IDLE;
            cmd_q      <= '0;
            data0_q    <= '0;
            tgt_q      <= TGT_NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_ok_q    <= 1'b0;
            wait_cnt   <= '0;
            oCmdErr    <= CMDERR_NONE;
            oRdata     <= '0;
            oRegnoNext <= '0;
        end else if (iAbort) begin
            state    <= SEQ_IDLE;
            tgt_q    <= TGT_NONE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (iStart) begin
                        cmd_q      <= access_reg_cmd_t'(iCommand);
                        data0_q    <= iData0;
                        oCmdErr    <= CMDERR_NONE;
                        rd_ok_q    <= 1'b0;
                        oRegnoNext <= iCommand[15:0] + 16'd1;
                        state      <= SEQ_DECODE;
                    end
                end
                SEQ_DECODE: begin
                    wait_cnt <= '0;
                    if (dec_cmderr != CMDERR_NONE || dec_target == TGT_NONE) begin
                        oCmdErr <= dec_cmderr;
                        state   <= SEQ_DONE;
                    end else begin
                        tgt_q   <= dec_target;
                        addr_q  <= dec_addr;
                        rd_en_q <= !cmd_q.write;
                        wr_en_q <= cmd_q.write;
                        wdata_q <= cmd_q.write ? data0_q : '0;
                        state   <= SEQ_ACCESS;
                    end
                end
                SEQ_ACCESS: begin
                    // Enables drop on the edge the count reaches the limit, so
                    // the request is visible for exactly TIMEOUT_CYCLES cycles.
                    if (wait_cnt == 17'(TIMEOUT_CYCLES)) begin
                        oCmdErr <= CMDERR_BUSERR;
                        tgt_q   <= TGT_NONE;
                        state   <= SEQ_DONE;
                    end else if (bus_ack) begin
                        if (rd_en_q) begin
                            oRdata  <= rdata_sel;
                            rd_ok_q <= 1'b1;
                        end
                        tgt_q   <= TGT_NONE;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        rd_en_q <= 1'b0;
                        wr_en_q <= 1'b0;
                        state   <= SEQ_DONE;
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                        if (wait_cnt_inc == 17'(TIMEOUT_CYCLES)) begin
                            addr_q  <= '0;
                            wdata_q <= '0;
                            rd_en_q <= 1'b0;
                            wr_en_q <= 1'b0;
                        end
                    end
                end
                SEQ_DONE: begin
                    state <= SEQ_IDLE;
                end
                default: begin
                    state <= SEQ_IDLE;
                end
            endcase
        end
    end

    assign oBusy          = (state != SEQ_IDLE);
    assign oDone          = (state == SEQ_DONE) && !iAbort;
    assign oRdataValid    = oDone && rd_ok_q;
    assign oRegnoInc      = oDone && cmd_q.aarpostincrement && (oCmdErr == CMDERR_NONE);
    assign oStartRejected = iStart && oBusy;

endmodule

// File: doc/dbg_abstract_seq.md
# dbg_abstract_seq

Abstract-command sequencer for the debug module: takes an accepted Access Register command and data0 from the DMI register file, validates it, and drives the processor's debug register-access buses (GPR file and CSR file) with a bounded-time read/write handshake. Reports completion, read data and a RISC-V debug `cmderr` code back to the debug module, which owns `abstractcs` and `data0`. Sits between the DMI register block and the `BBUS_IF` debug-access ports of the core.

## Interface
- `TIMEOUT_CYCLES`, 255: max cycles in ACCESS awaiting ack before bus error; 1..65535
- `iClk` in 1: clock
- `nRst` in 1: asynchronous active-low reset
- `iStart` in 1: one-cycle pulse, `iCommand`/`iData0` valid
- `iCommand` in 32: abstract command word
- `iData0` in 32: write data
- `iHalted` in 1: hart halted status
- `iAbort` in 1: synchronous abort (dmactive low), highest priority
- `oBusy` in→out 1: state != IDLE
- `oDone` out 1: one-cycle completion pulse (success or error)
- `oCmdErr` out 3: error of last command, held until next accepted start
- `oRdata` out 32: read result; `oRdataValid` out 1: pulse with `oDone` on successful read
- `oRegnoNext` out 16: regno+1 (wraps 0xFFFF→0x0000); `oRegnoInc` out 1: pulse with `oDone` when postincrement set and no error
- `oStartRejected` out 1: pulse when `iStart` arrives while busy
- `rf_bus` `BBUS_IF.master`: GPR access (addr, wdata, rdata, read_en, write_en, read_ack, write_ack)
- `csr_bus` `BBUS_IF.master`: CSR access, same signals

## Operation
- States: IDLE, DECODE, ACCESS, DONE.
- IDLE: on `iStart` latch command and `iData0`, clear `oCmdErr`, go DECODE.
- DECODE (one cycle), first matching rule wins:
  - cmdtype [31:24] != 0 → err 2 (nosupport), DONE.
  - `transfer` [17] = 0 → no access; err 0, DONE (postexec still checked).
  - `postexec` [18] = 1 → err 2, DONE.
  - `aarsize` [22:20] != 2 → err 2, DONE.
  - `iHalted` = 0 → err 4 (halt/resume), DONE.
  - regno 0x1000–0x101F → GPR, addr = regno[4:0]; regno 0x0000–0x0FFF → CSR, addr = regno[11:0]; else err 3 (exception), DONE.
  - Otherwise ACCESS.
- ACCESS: exactly one bus has `write_en` (`write` [16]=1, wdata = latched data0) or `read_en` asserted, other bus idle. Enables held every cycle until matching ack sampled high. Read ack: capture rdata into `oRdata`. Ack → DONE, err 0. Counter reaching `TIMEOUT_CYCLES` without ack → enables drop, err 5 (buserr), DONE.
- DONE: `oDone` pulse, `oRdataValid`/`oRegnoInc` as applicable, → IDLE.
- `iStart` outside IDLE: ignored, `oStartRejected` pulse; latched command unchanged.
- `iAbort` in any state: next state IDLE, enables deasserted that edge, no `oDone`, `oCmdErr` unchanged.

## Timing
- Reset: state IDLE, all outputs 0, all bus enables/addr/wdata 0, counter 0.
- Enables/addr/wdata are registered; asserted from first ACCESS cycle.
- Ack present in first ACCESS cycle: `iStart` at cycle 0 → DECODE 1 → ACCESS 2 → `oDone` cycle 3. Each extra wait cycle adds one.
- DECODE error: `oDone` at cycle 2.
- Timeout: `oDone` at cycle 3+`TIMEOUT_CYCLES`.
- `iStart` in DONE cycle is rejected; earliest new accept is the cycle after `oDone`.
- Ack on the non-targeted bus or wrong-type ack ignored.

## Structure
- Add to `debug_types` package: cmdtype constants (ARC=0, QA=1, AMC=2), `cmderr` constants (none/busy/nosupport/exception/exefail-halt/buserr/other), command field typedef for access-register, state enum, GPR/CSR regno range constants. The debug module migrates its local cmderr constants to the package.
- One sub-module: `dbg_abstract_decode`, combinational, mapping command + `iHalted` to {target, bus addr, cmderr}.

## Test plan
- Halted, `iCommand`=0x0022_1005 (read x5), `rf_bus.rdata`=0xDEADBEEF, ack in first ACCESS cycle → `oDone`+`oRdataValid` cycle 3, `oRdata`=0xDEADBEEF, `oCmdErr`=0.
- Halted, 0x0023_0341 write mepc, `iData0`=0x8000_0100, ack after 4 waits → `csr_bus` addr 0x341, wdata 0x8000_0100, `rf_bus` idle, `oDone` cycle 7.
- Not halted, 0x0022_1001 → no enables, `oDone` cycle 2, `oCmdErr`=4; aarsize=3 → 2; cmdtype 1 → 2; regno 0xC000 → 3.
- `TIMEOUT_CYCLES`=8, ack never → enables 8 cycles, `oCmdErr`=5, `oDone` cycle 11.
- Postincrement with regno 0x101F then 0xFFFF (transfer=0) → `oRegnoNext`=0x1020 then 0x0000, `oRegnoInc` pulse each.
- `iStart` mid-ACCESS → `oStartRejected`, first command completes unaltered; `iAbort` mid-ACCESS → enables low next edge, no `oDone`; `nRst` low mid-ACCESS → all outputs 0 immediately.
